// File: rtl/cp_add_pkg.sv
// Shared types and sizing helpers for the sequential nibble adder.
package cp_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int beats_of(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cp_rca_4b.sv
// 4-bit ripple-carry adder slice.
module cp_rca_4b
    import cp_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/cp_add_seq_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice reused over WIDTH/4 beats, LSB nibble first.
// Define CP_ADD_SEQ_OVF_EN to add the o_ovf signed-overflow output.
module cp_add_seq_ctrl
    import cp_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cy,
    output logic             o_busy
`ifdef CP_ADD_SEQ_OVF_EN
   ,output logic             o_ovf
`endif
);

    localparam int BEATS = beats_of(WIDTH);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cp_add_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_sh, b_sh, result;
    logic [SLICE_W-1:0] sum4;
    logic               cout4;
    logic               accept, beat, last_beat;

    cp_rca_4b u_slice (
        .a    (a_sh[SLICE_W-1:0]),
        .b    (b_sh[SLICE_W-1:0]),
        .cin  (carry),
        .s    (sum4),
        .cout (cout4)
    );

    assign accept    = (state == IDLE) && i_valid;
    assign beat      = (state == RUN);
    assign last_beat = beat && (cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_valid)     state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    if (i_ready)     state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // Sum nibbles enter from the top so the LSB nibble ends up at the bottom after BEATS shifts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
        end else if (accept) begin
            cnt    <= '0;
            carry  <= i_cin;
            a_sh   <= i_a;
            b_sh   <= i_b;
        end else if (beat) begin
            cnt    <= cnt + 1'b1;
            carry  <= cout4;
            a_sh   <= a_sh >> SLICE_W;
            b_sh   <= b_sh >> SLICE_W;
            result <= {sum4, result[WIDTH-1:SLICE_W]};
        end
    end

`ifdef CP_ADD_SEQ_OVF_EN
    logic ovf;

    // On the last beat the slice sees the operand sign bits and produces the sum sign bit.
    always_ff @(posedge i_clk) begin
        if (i_rst)          ovf <= 1'b0;
        else if (last_beat) ovf <= (a_sh[SLICE_W-1] == b_sh[SLICE_W-1]) &&
                                   (sum4[SLICE_W-1] != a_sh[SLICE_W-1]);
    end

    assign o_ovf = ovf;
`else
    logic unused_last_beat;
    assign unused_last_beat = last_beat;
`endif

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);
    assign o_valid = (state == DONE);
    assign o_s     = result;
    assign o_cy    = carry;

endmodule

// File: tb/tb_cp_add_seq_ctrl.sv
// Bench for cp_add_seq_ctrl at WIDTH 8, 16 and 32: timing/result model plus directed literals.
module tb_cp_add_seq_ctrl;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int W     = (gi == 0) ? 16 : (gi == 1) ? 8 : 32;
        localparam int BEATS = W / 4;

        logic         rst = 1'b1, valid = 1'b0, cin = 1'b0, iready = 1'b1;
        logic [W-1:0] a = '0, b = '0;
        logic         ready_o, ovalid, cy, busy;
        logic [W-1:0] s;
`ifdef CP_ADD_SEQ_OVF_EN
        logic         ovf;
`endif
        bit chk_on = 1'b0;
        bit fin    = 1'b0;

        cp_add_seq_ctrl #(.WIDTH(W)) dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_valid (valid),
            .o_ready (ready_o),
            .i_a     (a),
            .i_b     (b),
            .i_cin   (cin),
            .o_valid (ovalid),
            .i_ready (iready),
            .o_s     (s),
            .o_cy    (cy),
            .o_busy  (busy)
`ifdef CP_ADD_SEQ_OVF_EN
           ,.o_ovf   (ovf)
`endif
        );

        // Model: one transaction in flight; result due BEATS edges after the accepting edge.
        int           cyc = 0, due = 0;
        bit           pend = 1'b0;
        logic [W:0]   m_val = '0;
        bit           m_ovf = 1'b0;

        always @(posedge clk) begin
            bit vld_now;
            vld_now = pend && (cyc >= due);
            cyc++;
            if (rst) pend = 1'b0;
            else if (pend) begin
                if (vld_now && iready) pend = 1'b0;
            end else if (valid) begin
                pend  = 1'b1;
                due   = cyc + BEATS;
                m_val = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                m_ovf = (a[W-1] == b[W-1]) && (m_val[W-1] != a[W-1]);
            end
        end

        always @(negedge clk) begin
            bit ev;
            if (chk_on) begin
                ev = pend && (cyc >= due);
                chk($sformatf("w%0d o_valid", W), 64'(ovalid), 64'(ev));
                chk($sformatf("w%0d o_ready", W), 64'(ready_o), 64'(!pend));
                chk($sformatf("w%0d o_busy", W), 64'(busy), 64'(pend));
                if (ev) begin
                    chk($sformatf("w%0d o_s", W), 64'(s), 64'(m_val[W-1:0]));
                    chk($sformatf("w%0d o_cy", W), 64'(cy), 64'(m_val[W]));
`ifdef CP_ADD_SEQ_OVF_EN
                    chk($sformatf("w%0d o_ovf", W), 64'(ovf), 64'(m_ovf));
`endif
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic do_reset();
            rst = 1'b1; valid = 1'b0; iready = 1'b1; a = '0; b = '0; cin = 1'b0;
            tick();
            tick();
            chk($sformatf("w%0d rst o_valid", W), 64'(ovalid), 64'd0);
            chk($sformatf("w%0d rst o_s", W), 64'(s), 64'd0);
            chk($sformatf("w%0d rst o_cy", W), 64'(cy), 64'd0);
            chk($sformatf("w%0d rst o_ready", W), 64'(ready_o), 64'd1);
            chk($sformatf("w%0d rst o_busy", W), 64'(busy), 64'd0);
`ifdef CP_ADD_SEQ_OVF_EN
            chk($sformatf("w%0d rst o_ovf", W), 64'(ovf), 64'd0);
`endif
            rst = 1'b0;
            chk_on = 1'b1;
        endtask

        task automatic rand_ops(input int n);
            int guard;
            bit acc;
            for (int k = 0; k < n; k++) begin
                valid = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom_range(0, 1));
                guard = 0;
                do begin
                    iready = ($urandom_range(0, 3) != 0);
                    acc    = ready_o;
                    tick();
                    guard++;
                end while (!acc && guard < 100);
                chk($sformatf("w%0d accept_timeout", W), 64'(acc), 64'd1);
            end
            valid  = 1'b0;
            iready = 1'b1;
            guard  = 0;
            while (busy && guard < 50) begin
                tick();
                guard++;
            end
            chk($sformatf("w%0d drain", W), 64'(busy), 64'd0);
        endtask

        if (gi == 0) begin : g_dir
            task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                              output logic [W-1:0] rs, output logic rc, output logic ro,
                              output int lat);
                valid = 1'b1; a = ta; b = tb; cin = tc; iready = 1'b1;
                tick();
                valid = 1'b0;
                lat   = 0;
                do begin
                    tick();
                    lat++;
                end while (!ovalid && lat < 20);
                rs = s;
                rc = cy;
`ifdef CP_ADD_SEQ_OVF_EN
                ro = ovf;
`else
                ro = 1'b0;
`endif
                tick();
            endtask

            initial begin
                logic [W-1:0] rs;
                logic         rc, ro;
                int           lat, g;

                do_reset();

                op(16'h00FF, 16'h0001, 1'b0, rs, rc, ro, lat);
                chk("d1 s", 64'(rs), 64'h0100);
                chk("d1 cy", 64'(rc), 64'd0);
                chk("d1 latency", 64'(lat), 64'd4);
                chk("d1 valid_one_cycle", 64'(ovalid), 64'd0);

                op(16'hFFFF, 16'h0000, 1'b1, rs, rc, ro, lat);
                chk("d2 s", 64'(rs), 64'h0000);
                chk("d2 cy", 64'(rc), 64'd1);
`ifdef CP_ADD_SEQ_OVF_EN
                chk("d2 ovf", 64'(ro), 64'd0);
`endif

                op(16'h7FFF, 16'h0001, 1'b0, rs, rc, ro, lat);
                chk("d3 s", 64'(rs), 64'h8000);
                chk("d3 cy", 64'(rc), 64'd0);
`ifdef CP_ADD_SEQ_OVF_EN
                chk("d3 ovf", 64'(ro), 64'd1);
`endif

                op(16'h8000, 16'h8000, 1'b0, rs, rc, ro, lat);
                chk("d4 s", 64'(rs), 64'h0000);
                chk("d4 cy", 64'(rc), 64'd1);
`ifdef CP_ADD_SEQ_OVF_EN
                chk("d4 ovf", 64'(ro), 64'd1);
`endif

                // Backpressure while new operands are offered.
                valid = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; iready = 1'b0;
                tick();
                a = 16'h1111; b = 16'h2222;
                g = 0;
                while (!ovalid && g < 20) begin
                    tick();
                    g++;
                end
                for (int k = 0; k < 3; k++) begin
                    chk("bp s", 64'(s), 64'h1010);
                    chk("bp cy", 64'(cy), 64'd0);
                    chk("bp ready", 64'(ready_o), 64'd0);
                    chk("bp valid", 64'(ovalid), 64'd1);
                    tick();
                end
                iready = 1'b1; valid = 1'b0;
                tick();
                chk("bp after valid", 64'(ovalid), 64'd0);
                chk("bp after ready", 64'(ready_o), 64'd1);

                // Reset during beat 2 aborts the operation.
                valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
                tick();
                valid = 1'b0;
                tick();
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort valid", 64'(ovalid), 64'd0);
                chk("abort ready", 64'(ready_o), 64'd1);
                chk("abort busy", 64'(busy), 64'd0);
                chk("abort s", 64'(s), 64'd0);
                for (int k = 0; k < 6; k++) begin
                    tick();
                    chk("abort no_result", 64'(ovalid), 64'd0);
                end

                op(16'h1234, 16'h4321, 1'b0, rs, rc, ro, lat);
                chk("d5 s", 64'(rs), 64'h5555);
                chk("d5 cy", 64'(rc), 64'd0);

                rand_ops(1000);
                fin = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                do_reset();
                rand_ops(1000);
                fin = 1'b1;
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (!(g_w[0].fin && g_w[1].fin && g_w[2].fin)) begin
            failures++;
            $display("FAIL run_timeout: got %0d cycles expected completion", t);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
